tt_result_serializer: RTL and testbench
=======================================

Name: tt_result_serializer

Overview:
- Downstream stage of the pin-level logic unit in the Tiny Tapeout user design.
- Captures each 8-bit XOR result / 8-bit AND result pair on a valid/ready handshake and buffers it in a small FIFO.
- Transmits each pair on a single output pin as a framed serial word (start, 16 data bits, optional even parity, stop), so results can be read off one uo_out bit.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- CLK_DIV, 4, clock cycles per serial bit (>=1)
- PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = omit it

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  result pair present on xor_data/and_data
- in_ready  out  1  FIFO can accept; high when count < DEPTH
- xor_data  in  8  XOR result from logic stage
- and_data  in  8  AND result from logic stage
- clr_ovf  in  1  synchronous clear of overflow flag
- tx_out  out  1  serial line, idle high
- tx_busy  out  1  high while a frame is on tx_out
- fifo_count  out  $clog2(DEPTH)+1  entries stored
- overflow  out  1  sticky: in_valid seen while in_ready low

Behaviour:
- Reset (async, immediate):
  - tx_out=1, tx_busy=0, in_ready=1, fifo_count=0, overflow=0.
  - FIFO emptied; FSM to IDLE; bit and divider counters zeroed.
  - Reset mid-frame aborts the frame; line returns high at once.
- Push:
  - in_valid & in_ready at a rising edge writes word {xor_data, and_data} (xor in bits 15:8).
- Pop:
  - Occurs on the edge where the FSM leaves IDLE or STOP toward START with FIFO non-empty.
  - The popped word loads the shift register.
- Simultaneous push+pop:
  - Both take effect; count unchanged.
  - in_ready is a function of the registered count only, so a full FIFO refuses a push even on a pop cycle.
- Overflow:
  - Set on any edge with in_valid & !in_ready.
  - Cleared by clr_ovf; set wins if both occur on the same edge.
  - The offered data is dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1. If count>0 -> START (pop).
  - START: tx_out=0 for CLK_DIV cycles -> DATA.
  - DATA: 16 bits, MSB (bit 15) first, each held CLK_DIV cycles. After bit 0 -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx_out = XOR of all 16 data bits, so total ones including the parity bit are even. Held CLK_DIV cycles -> STOP.
  - STOP: tx_out=1 for CLK_DIV cycles. Then START with pop if count>0, with no idle gap; otherwise IDLE.
- Latency:
  - A word pushed into an empty FIFO with the FSM in IDLE at edge N.
  - FSM enters START at edge N+1.
  - tx_out falls after edge N+1.
- Frame length: (18 + PARITY_EN) * CLK_DIV cycles.
- tx_busy is high in every state except IDLE.
- Divider:
  - Counts 0..CLK_DIV-1 and restarts on every state or bit change.
  - CLK_DIV=1 gives one cycle per bit.
- FIFO pointers wrap modulo DEPTH. fifo_count saturates logically at DEPTH because no push is accepted when full.
- All outputs are registered except in_ready, which is decoded combinationally from the registered count.

Decomposition:
- Shared package tt_serial_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - DATA_BITS=16
  - a frame-length helper function
- One sub-module, tt_sync_fifo:
  - parameterised width and depth
  - push/pop, count, full/empty
  - async active-high reset
- The top level holds the FSM, divider, shift register and overflow flag.

Test Plan:
- Single word, CLK_DIV=4, PARITY_EN=1: push xor=0xA5, and=0x3C.
  - Required line sequence: start 0; data 1010_0101_0011_1100; parity 0; stop 1.
  - Each bit lasts 4 cycles; 76 cycles total.
  - tx_busy high for exactly 76 cycles.
- Back-to-back: push 0xFF/0x01 and 0x00/0x00.
  - Second start bit follows first stop bit with no idle cycle.
  - First parity=1 (9 ones); second parity=0.
- Fill/overflow: hold FSM in a frame, push 4 words -> fifo_count=4, in_ready=0.
  - A 5th in_valid sets overflow=1 and count stays 4.
  - clr_ovf -> overflow=0.
  - All 4 words emerge intact in order.
- Push and pop on the same edge with count=2 -> count stays 2 and data order is preserved.
- Reset mid-DATA: assert rst during bit 7.
  - tx_out=1, tx_busy=0 and fifo_count=0 in the same cycle.
  - After release, the line stays idle with no frame.
- PARITY_EN=0, CLK_DIV=1: push 0x80/0x00.
  - Frame is 18 cycles: 0, then 1 followed by fifteen 0s, then 1.

Source files
------------

// File: rtl/tt_serial_pkg.sv
// Shared types and constants for the result serializer: FSM states, payload layout, frame length.
package tt_serial_pkg;

  localparam int unsigned DATA_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef struct packed {
    logic [7:0] xor_res;
    logic [7:0] and_res;
  } result_pair_t;

  // Clock cycles occupied by one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_cycles(input int unsigned clk_div, input bit parity_en);
    return (DATA_BITS + 2 + (parity_en ? 1 : 0)) * clk_div;
  endfunction

endpackage

// File: rtl/tt_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes are ignored when full, pops when empty.
module tt_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tt_result_serializer.sv
// Buffers XOR/AND result pairs and shifts each out on one pin as a start/16-bit/parity/stop frame.
module tt_result_serializer
  import tt_serial_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             xor_data,
  input  logic [7:0]             and_data,
  input  logic                   clr_ovf,
  output logic                   tx_out,
  output logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;

  result_pair_t         in_pair;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;
  logic                 bit_done;

  assign in_pair  = '{xor_res: xor_data, and_res: and_data};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign bit_done = (div_q == DIV_W'(CLK_DIV - 1));

  tt_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_pair),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next state, pop decision and registered-output values.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;
    tx_d     = 1'b1;
    busy_d   = 1'b0;
    ovf_d    = ovf_q;

    if (state_q != ST_IDLE) div_d = bit_done ? '0 : div_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            state_d = ST_START;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d  = fifo_rdata;
      parity_d = ^fifo_rdata;
      bit_d    = '0;
    end

    // Line level follows the state being entered so it lines up with the state register.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[DATA_BITS-1];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);

    if (clr_ovf) ovf_d = 1'b0;
    if (in_valid && !in_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_out   = tx_q;
  assign tx_busy  = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tt_result_serializer.sv
// Bench for tt_result_serializer: exact line traces for directed cases plus a random frame-decoding run.
module tb_tt_result_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_valid, a_clr, a_ready, a_tx, a_busy, a_ovf;
  logic [7:0] a_xor, a_and;
  logic [2:0] a_count;
  logic       b_valid, b_clr, b_ready, b_tx, b_busy, b_ovf;
  logic [7:0] b_xor, b_and;
  logic [2:0] b_count;

  tt_result_serializer #(.DEPTH(4), .CLK_DIV(4), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .xor_data(a_xor), .and_data(a_and), .clr_ovf(a_clr),
    .tx_out(a_tx), .tx_busy(a_busy), .fifo_count(a_count), .overflow(a_ovf)
  );

  tt_result_serializer #(.DEPTH(4), .CLK_DIV(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .xor_data(b_xor), .and_data(b_and), .clr_ovf(b_clr),
    .tx_out(b_tx), .tx_busy(b_busy), .fifo_count(b_count), .overflow(b_ovf)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  bit   rec_en = 1'b0;
  logic rec_a_tx[$], rec_a_busy[$], rec_b_tx[$], rec_b_busy[$];
  logic exp_tx[$], exp_busy[$];
  logic [15:0] words_q[$];

  // Line recorder: one sample per cycle, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rec_en) begin
      rec_a_tx.push_back(a_tx);
      rec_a_busy.push_back(a_busy);
      rec_b_tx.push_back(b_tx);
      rec_b_busy.push_back(b_busy);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_rec();
    rec_a_tx.delete(); rec_a_busy.delete();
    rec_b_tx.delete(); rec_b_busy.delete();
    exp_tx.delete(); exp_busy.delete();
    rec_en = 1'b1;
  endtask

  task automatic exp_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  // Expected line for one word: start, MSB-first data, optional even parity, stop.
  task automatic exp_frame(input logic [15:0] w, input int cdiv, input bit par);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 15; i >= 0; i--) bits.push_back(w[i]);
    if (par) bits.push_back(^w);
    bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < cdiv; k++) begin
        exp_tx.push_back(bits[i]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  task automatic drive_a(input logic [15:0] w);
    a_valid = 1'b1;
    a_xor   = w[15:8];
    a_and   = w[7:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid = 1'b0; a_clr = 1'b0; a_xor = '0; a_and = '0;
    b_valid = 1'b0; b_clr = 1'b0; b_xor = '0; b_and = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (a_tx !== 1'b1)    begin tests_failed++; $display("FAIL reset_a_tx: got %b want 1", a_tx); end
    tests_run++; if (a_busy !== 1'b0)  begin tests_failed++; $display("FAIL reset_a_busy: got %b want 0", a_busy); end
    tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
    tests_run++; if (a_count !== 3'd0) begin tests_failed++; $display("FAIL reset_a_count: got %0d want 0", a_count); end
    tests_run++; if (a_ovf !== 1'b0)   begin tests_failed++; $display("FAIL reset_a_ovf: got %b want 0", a_ovf); end
    tests_run++; if (b_tx !== 1'b1 || b_busy !== 1'b0 || b_ready !== 1'b1 || b_count !== 3'd0 || b_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_b: got tx=%b busy=%b ready=%b count=%0d ovf=%b want 1 0 1 0 0", b_tx, b_busy, b_ready, b_count, b_ovf);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_idle: got tx=%b busy=%b want 1 0", a_tx, a_busy);
    end
  endtask

  task automatic test_single_frame();
    @(negedge clk);
    start_rec();
    drive_a(16'hA53C);
    exp_idle(1); exp_frame(16'hA53C, 4, 1'b1); exp_idle(3);
    @(negedge clk);
    a_valid = 1'b0;
    while (rec_a_tx.size() < exp_tx.size()) @(negedge clk);
    rec_en = 1'b0;
    foreach (exp_tx[i]) begin
      tests_run++;
      if (rec_a_tx[i] !== exp_tx[i] || rec_a_busy[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL single cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", i, rec_a_tx[i], rec_a_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start_rec();
    drive_a(16'hFF01);
    @(negedge clk);
    drive_a(16'h0000);
    @(negedge clk);
    a_valid = 1'b0;
    exp_idle(1); exp_frame(16'hFF01, 4, 1'b1); exp_frame(16'h0000, 4, 1'b1); exp_idle(3);
    while (rec_a_tx.size() < exp_tx.size()) @(negedge clk);
    rec_en = 1'b0;
    foreach (exp_tx[i]) begin
      tests_run++;
      if (rec_a_tx[i] !== exp_tx[i] || rec_a_busy[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL b2b cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", i, rec_a_tx[i], rec_a_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_fill_overflow();
    logic [15:0] w[5];
    foreach (w[k]) w[k] = 16'($urandom);
    @(negedge clk);
    start_rec();
    drive_a(w[0]);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      drive_a(w[k]);
    end
    @(negedge clk);
    tests_run++; if (a_count !== 3'd4) begin tests_failed++; $display("FAIL fill_count: got %0d want 4", a_count); end
    tests_run++; if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_ready: got %b want 0", a_ready); end
    tests_run++; if (a_ovf !== 1'b0)   begin tests_failed++; $display("FAIL fill_ovf_pre: got %b want 0", a_ovf); end
    drive_a(16'(~w[4]));
    @(negedge clk);
    tests_run++; if (a_ovf !== 1'b1)   begin tests_failed++; $display("FAIL ovf_set: got %b want 1", a_ovf); end
    tests_run++; if (a_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d want 4", a_count); end
    a_clr = 1'b1;
    @(negedge clk);
    tests_run++; if (a_ovf !== 1'b1)   begin tests_failed++; $display("FAIL ovf_set_wins: got %b want 1", a_ovf); end
    a_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (a_ovf !== 1'b0)   begin tests_failed++; $display("FAIL ovf_clear: got %b want 0", a_ovf); end
    tests_run++; if (a_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count_after: got %0d want 4", a_count); end
    a_clr = 1'b0;
    exp_idle(1);
    foreach (w[k]) exp_frame(w[k], 4, 1'b1);
    exp_idle(3);
    while (rec_a_tx.size() < exp_tx.size()) @(negedge clk);
    rec_en = 1'b0;
    foreach (exp_tx[i]) begin
      tests_run++;
      if (rec_a_tx[i] !== exp_tx[i] || rec_a_busy[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL fill_trace cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", i, rec_a_tx[i], rec_a_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_push_pop_same_edge();
    logic [15:0] w[4];
    foreach (w[k]) w[k] = 16'($urandom);
    @(negedge clk);
    start_rec();
    drive_a(w[0]);
    @(negedge clk); drive_a(w[1]);
    @(negedge clk); drive_a(w[2]);
    @(negedge clk); a_valid = 1'b0;
    repeat (74) @(negedge clk);
    tests_run++; if (a_count !== 3'd2) begin tests_failed++; $display("FAIL pp_count_pre: got %0d want 2", a_count); end
    drive_a(w[3]);
    @(negedge clk);
    a_valid = 1'b0;
    tests_run++; if (a_count !== 3'd2) begin tests_failed++; $display("FAIL pp_count_post: got %0d want 2", a_count); end
    tests_run++; if (a_tx !== 1'b0)    begin tests_failed++; $display("FAIL pp_next_start: got %b want 0", a_tx); end
    exp_idle(1);
    foreach (w[k]) exp_frame(w[k], 4, 1'b1);
    exp_idle(3);
    while (rec_a_tx.size() < exp_tx.size()) @(negedge clk);
    rec_en = 1'b0;
    foreach (exp_tx[i]) begin
      tests_run++;
      if (rec_a_tx[i] !== exp_tx[i] || rec_a_busy[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL pp_trace cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", i, rec_a_tx[i], rec_a_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_reset_mid_data();
    @(negedge clk); drive_a(16'h5A5A);
    @(negedge clk); drive_a(16'h1234);
    @(negedge clk); a_valid = 1'b0;
    repeat (37) @(negedge clk);
    tests_run++; if (a_busy !== 1'b1 || a_count !== 3'd1) begin
      tests_failed++; $display("FAIL midrst_pre: got busy=%b count=%0d want 1 1", a_busy, a_count);
    end
    rst = 1'b1;
    #1;
    tests_run++; if (a_tx !== 1'b1)    begin tests_failed++; $display("FAIL midrst_tx: got %b want 1", a_tx); end
    tests_run++; if (a_busy !== 1'b0)  begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", a_busy); end
    tests_run++; if (a_count !== 3'd0) begin tests_failed++; $display("FAIL midrst_count: got %0d want 0", a_count); end
    @(negedge clk);
    rst = 1'b0;
    start_rec();
    exp_idle(40);
    while (rec_a_tx.size() < exp_tx.size()) @(negedge clk);
    rec_en = 1'b0;
    foreach (exp_tx[i]) begin
      tests_run++;
      if (rec_a_tx[i] !== exp_tx[i] || rec_a_busy[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL midrst_idle cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", i, rec_a_tx[i], rec_a_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_noparity_div1();
    @(negedge clk);
    start_rec();
    b_valid = 1'b1; b_xor = 8'h80; b_and = 8'h00;
    @(negedge clk);
    b_valid = 1'b0;
    exp_idle(1); exp_frame(16'h8000, 1, 1'b0); exp_idle(3);
    while (rec_b_tx.size() < exp_tx.size()) @(negedge clk);
    rec_en = 1'b0;
    foreach (exp_tx[i]) begin
      tests_run++;
      if (rec_b_tx[i] !== exp_tx[i] || rec_b_busy[i] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL nopar cyc%0d: got tx=%b busy=%b want tx=%b busy=%b", i, rec_b_tx[i], rec_b_busy[i], exp_tx[i], exp_busy[i]);
      end
    end
  endtask

  // Random pushes honouring in_ready; a receiver decodes each frame at mid-bit and checks order and content.
  task automatic test_random();
    localparam int NWORDS = 20;
    words_q.delete();
    @(negedge clk);
    fork
      begin
        for (int n = 0; n < NWORDS; n++) begin
          logic [15:0] w;
          int guard;
          w = 16'($urandom);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          guard = 0;
          while (a_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
          end
          tests_run++;
          if (guard >= 1000) begin
            tests_failed++; $display("FAIL rnd_ready_timeout: got ready=%b want 1", a_ready);
            break;
          end
          drive_a(w);
          words_q.push_back(w);
          @(negedge clk);
          a_valid = 1'b0;
        end
      end
      begin
        for (int n = 0; n < NWORDS; n++) begin
          logic [18:0] got, want;
          logic [15:0] ew;
          int guard;
          guard = 0;
          while (a_tx !== 1'b0 && guard < 2000) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 2000) begin
            tests_run++; tests_failed++;
            $display("FAIL rnd_frame_timeout: got no start bit, want frame %0d", n);
            break;
          end
          got = '0;
          for (int t = 1; t <= 74; t++) begin
            @(negedge clk);
            if (t % 4 == 2) got[18 - t / 4] = a_tx;
          end
          tests_run++;
          if (words_q.size() == 0) begin
            tests_failed++; $display("FAIL rnd_unexpected_frame: got %h want none", got);
          end else begin
            ew   = words_q.pop_front();
            want = {1'b0, ew, ^ew, 1'b1};
            if (got !== want) begin
              tests_failed++; $display("FAIL rnd_frame%0d: got %b want %b", n, got, want);
            end
          end
        end
      end
    join
    repeat (10) @(negedge clk);
    tests_run++; if (a_ovf !== 1'b0)   begin tests_failed++; $display("FAIL rnd_ovf: got %b want 0", a_ovf); end
    tests_run++; if (a_count !== 3'd0 || words_q.size() != 0) begin
      tests_failed++; $display("FAIL rnd_drain: got count=%0d left=%0d want 0 0", a_count, words_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fill_overflow();
    test_push_pop_same_edge();
    test_reset_mid_data();
    test_noparity_div1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
